// File: rtl/keypad_scanner.sv
// Column-scanning 4x3 keypad decoder: strobes columns, builds a 12-key frame,
// debounces whole frames and reports one key per press/release cycle.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Row,
    output logic [2:0] Col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);
    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned KEYS   = 12;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESSED = 1'b1
    } state_t;

    logic [SLOT_W-1:0] slot_q;
    logic [2:0]        col_q;
    logic              slot_end;
    logic              frame_end;
    logic [KEYS-1:0]   acc_q;
    logic [KEYS-1:0]   acc_d;
    logic [KEYS-1:0]   frame_q;
    logic              frame_vld_q;
    logic [KEYS-1:0]   prev_q;
    logic [KEYS-1:0]   deb_q;
    logic              deb_vld_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [3:0]        deb_idx;
    logic              deb_onehot;
    state_t            state_q;
    state_t            state_d;
    logic              key_valid_q;
    logic              key_valid_d;
    logic [3:0]        key_code_q;
    logic [3:0]        key_code_d;
    logic              key_held_q;
    logic              key_held_d;

    assign slot_end  = (slot_q == SLOT_W'(SCAN_DIV - 1));
    assign frame_end = slot_end & col_q[2];

    // Merge the current row returns into the bits of the strobed column.
    always_comb begin
        acc_d = acc_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (col_q[c]) begin
                    acc_d[3*r + c] = Row[r];
                end
            end
        end
    end

    // Column strobe rotation, end-of-slot sampling and frame snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q      <= '0;
            col_q       <= 3'b001;
            acc_q       <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
        end else begin
            frame_vld_q <= frame_end;
            if (slot_end) begin
                slot_q <= '0;
                col_q  <= {col_q[1:0], col_q[2]};
                acc_q  <= acc_d;
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
            if (frame_end) begin
                frame_q <= acc_d;
            end
        end
    end

    // Saturating count of consecutive identical frames.
    always_comb begin
        cnt_d = CNT_W'(1);
        if (frame_q == prev_q) begin
            cnt_d = (cnt_q < CNT_W'(DEBOUNCE)) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            deb_q     <= '0;
            deb_vld_q <= 1'b0;
        end else begin
            deb_vld_q <= frame_vld_q;
            if (frame_vld_q) begin
                prev_q <= frame_q;
                cnt_q  <= cnt_d;
                if (cnt_d == CNT_W'(DEBOUNCE)) begin
                    deb_q <= frame_q;
                end
            end
        end
    end

    always_comb begin
        deb_idx = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            if (deb_q[i]) begin
                deb_idx = 4'(i);
            end
        end
        deb_onehot = (deb_q != '0) && ((deb_q & (deb_q - KEYS'(1))) == '0);
    end

    // Press/release tracker; a new key is only accepted from a full release.
    always_comb begin
        state_d     = state_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        if (deb_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (deb_onehot) begin
                        state_d     = S_PRESSED;
                        key_valid_d = 1'b1;
                        key_code_d  = deb_idx;
                        key_held_d  = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (deb_q == '0) begin
                        state_d    = S_IDLE;
                        key_held_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign Col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner: a frame-level key model
// predicts press events and held state; a monitor checks the DUT against it.
module tb_keypad_scanner;
    localparam int unsigned SD = 4;
    localparam int unsigned DB = 2;
    localparam int unsigned FL = 3 * SD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  Row;
    logic [2:0]  Col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    logic [11:0] mask  = '0;
    logic [11:0] noise = '0;
    logic [11:0] eff;
    int unsigned cyc   = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned cyc;
        int unsigned code;
        bit          held;
    } exp_t;

    exp_t ev_q[$];
    exp_t held_q[$];
    exp_t mon_e;

    logic [11:0] m_prev;
    logic [11:0] m_deb;
    int unsigned m_cnt;
    int unsigned m_frame;
    int unsigned m_code;
    bit          m_pressed;

    logic [11:0] m;
    int unsigned sel;
    int unsigned nrep;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clock     (clock),
        .reset     (reset),
        .Row       (Row),
        .Col       (Col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a row returns high when a pressed key sits on the strobed column.
    assign eff = mask ^ noise;
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            Row[r] = |(eff[3*r +: 3] & Col);
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] key(input int k);
        return 12'(1) << k;
    endfunction

    task automatic model_reset();
        m_prev    = '0;
        m_deb     = '0;
        m_cnt     = 0;
        m_frame   = 0;
        m_code    = 0;
        m_pressed = 1'b0;
    endtask

    // Frame-level behaviour: debounce whole snapshots, report a single key after full release.
    task automatic model_frame(input logic [11:0] f);
        exp_t e;
        m_frame++;
        if (f == m_prev) begin
            if (m_cnt < DB) m_cnt++;
        end else begin
            m_cnt = 1;
        end
        m_prev = f;
        if (m_cnt == DB) m_deb = f;
        if (!m_pressed && $countones(m_deb) == 1) begin
            m_pressed = 1'b1;
            for (int i = 0; i < 12; i++) if (m_deb[i]) m_code = i;
            e.cyc  = FL * m_frame + 2;
            e.code = m_code;
            e.held = 1'b1;
            ev_q.push_back(e);
        end else if (m_pressed && m_deb == '0) begin
            m_pressed = 1'b0;
        end
        e.cyc  = FL * m_frame + 2;
        e.code = m_code;
        e.held = m_pressed;
        held_q.push_back(e);
    endtask

    // One full scan frame; optional noise avoids the cycle before each sample edge.
    task automatic run_frame(input logic [11:0] f, input bit noisy);
        mask = f;
        model_frame(f);
        for (int t = 0; t < int'(FL); t++) begin
            noise = (noisy && (t % int'(SD)) != int'(SD) - 1) ? 12'($urandom) : 12'h000;
            @(posedge clock);
            @(negedge clock);
        end
        noise = '0;
    endtask

    task automatic do_reset(input logic [11:0] hold);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_col", int'(Col), 1);
        check("rst_valid", int'(key_valid), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_held", int'(key_held), 0);
        check("pending_at_reset", ev_q.size(), 0);
        ev_q.delete();
        held_q.delete();
        model_reset();
        mask  = hold;
        noise = '0;
        repeat (2) @(negedge clock);
        check("inrst_held", int'(key_held), 0);
        check("inrst_col", int'(Col), 1);
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("col_strobe", int'(Col), int'(1 << ((cyc / SD) % 3)));
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL key_valid missing: code %0d required at cycle %0d, none by cycle %0d",
                         ev_q[0].code, ev_q[0].cyc, cyc);
                ev_q.delete(0);
            end
            if (key_valid) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL key_valid unexpected: code %0d at cycle %0d, no pulse required",
                             key_code, cyc);
                end else begin
                    mon_e = ev_q.pop_front();
                    check("pulse_cycle", int'(cyc), int'(mon_e.cyc));
                    check("pulse_code", int'(key_code), int'(mon_e.code));
                end
            end
            if (held_q.size() > 0 && held_q[0].cyc == cyc) begin
                mon_e = held_q.pop_front();
                check("key_held", int'(key_held), int'(mon_e.held));
                check("held_code", int'(key_code), int'(mon_e.code));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset(12'h000);

        // Key 5 held from reset release, then released.
        repeat (3) run_frame(key(5), 1'b0);
        repeat (3) run_frame(12'h000, 1'b0);

        // Every key in turn, with inter-sample noise on odd keys.
        for (int k = 0; k < 12; k++) begin
            repeat (2) run_frame(key(k), (k % 2) == 1);
            repeat (2) run_frame(12'h000, 1'b0);
        end

        // Bounce on key 7, then stable.
        for (int i = 0; i < 5; i++) run_frame((i % 2) == 0 ? key(7) : 12'h000, 1'b0);
        repeat (3) run_frame(key(7), 1'b0);
        repeat (2) run_frame(12'h000, 1'b0);

        // Multi-key rejection and rollover.
        repeat (3) run_frame(key(3) | key(4), 1'b0);
        repeat (2) run_frame(12'h000, 1'b0);
        repeat (2) run_frame(key(2), 1'b0);
        repeat (3) run_frame(key(2) | key(8), 1'b1);
        repeat (3) run_frame(key(8), 1'b0);
        repeat (2) run_frame(12'h000, 1'b0);

        // Random key patterns with random hold lengths.
        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 4);
            if (sel == 0)      m = 12'h000;
            else if (sel < 4)  m = key(int'($urandom_range(0, 11)));
            else               m = key(int'($urandom_range(0, 11))) | key(int'($urandom_range(0, 11)));
            nrep = $urandom_range(1, 3);
            repeat (nrep) run_frame(m, $urandom_range(0, 1) == 1);
        end
        repeat (2) run_frame(12'h000, 1'b0);

        // Reset while key 9 is held; it is reported again afterwards.
        repeat (3) run_frame(key(9), 1'b0);
        do_reset(key(9));
        repeat (3) run_frame(key(9), 1'b0);
        repeat (2) run_frame(12'h000, 1'b0);

        repeat (3) @(negedge clock);
        check("pending_final", ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
